// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: drains the transmit FIFO and shifts each word onto the
// UART TX line LSB-first as start / data / (parity) / stop.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line high, waiting for Tx_En=1 and a non-empty FIFO
// FETCH   | single-cycle FIFO pop (Read=1)
// LOAD    | capture registered FIFO word, clear counters
// START   | start bit (Tx=0) for BAUD_DIV cycles
// DATA    | DATA_WIDTH data bits, LSB first
// PARITY  | even parity of the captured word (only with UART_TX_PARITY_EN)
// STOP    | stop bit (Tx=1); Tx_Done pulses as IDLE is re-entered
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 868
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Tx_En,
    input  logic [3:0]            Fifo_Status,
    input  logic [DATA_WIDTH-1:0] Fifo_Data,
    output logic                  Read,
    output logic                  Tx,
    output logic                  Busy,
    output logic                  Tx_Done
);

    localparam int               BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [15:0]           baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_adv;
    logic                  baud_wrap;
    logic                  bit_last;
    logic                  fifo_empty;
    logic                  read_d;
    logic                  tx_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  unused_status;
`ifdef UART_TX_PARITY_EN
    logic                  parity_acc;
    logic                  parity_out;
`endif

    // Only the Empty flag drives decisions; the other status bits are ignored.
    assign fifo_empty    = Fifo_Status[0];
    assign unused_status = ^Fifo_Status[3:1];

    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign bit_last  = (bit_cnt == BIT_LAST);

    // Shift register contents as they will be after this edge; drives the next data bit.
    assign shift_adv = (state == S_DATA && baud_wrap) ? (shift_reg >> 1) : shift_reg;

`ifdef UART_TX_PARITY_EN
    // The last data bit is folded in on the same edge that enters PARITY.
    assign parity_out = (state == S_DATA) ? (parity_acc ^ shift_reg[0]) : parity_acc;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (Tx_En && !fifo_empty) next_state = S_FETCH;
            S_FETCH:  next_state = S_LOAD;
            S_LOAD:   next_state = S_START;
            S_START:  if (baud_wrap) next_state = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (baud_wrap && bit_last) next_state = S_PARITY;
            S_PARITY: if (baud_wrap) next_state = S_STOP;
`else
            S_DATA:   if (baud_wrap && bit_last) next_state = S_STOP;
`endif
            S_STOP:   if (baud_wrap) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so registered outputs line up with it.
    always_comb begin
        read_d = (next_state == S_FETCH);
        busy_d = (next_state != S_IDLE);
        done_d = (state == S_STOP) && baud_wrap;
        tx_d   = 1'b1;
        case (next_state)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_adv[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_out;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // Output registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Read    <= 1'b0;
            Tx      <= 1'b1;
            Busy    <= 1'b0;
            Tx_Done <= 1'b0;
        end else begin
            Read    <= read_d;
            Tx      <= tx_d;
            Busy    <= busy_d;
            Tx_Done <= done_d;
        end
    end

    // Baud counter, bit counter, shift register and parity accumulator.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_acc <= 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    shift_reg <= Fifo_Data;
                    baud_cnt  <= '0;
                    bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
                    parity_acc <= 1'b0;
`endif
                end
                S_DATA: begin
                    baud_cnt <= baud_wrap ? 16'd0 : baud_cnt + 16'd1;
                    if (baud_wrap) begin
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_last ? '0 : bit_cnt + BIT_W'(1);
`ifdef UART_TX_PARITY_EN
                        parity_acc <= parity_acc ^ shift_reg[0];
`endif
                    end
                end
                S_START, S_STOP: begin
                    baud_cnt <= baud_wrap ? 16'd0 : baud_cnt + 16'd1;
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    baud_cnt <= baud_wrap ? 16'd0 : baud_cnt + 16'd1;
                end
`endif
                default: begin
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer (BAUD_DIV=4, DATA_WIDTH=8).
// Build with UART_TX_PARITY_EN defined to exercise the parity frames.
module tb_uart_tx_serializer;

    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Tx_En;
    logic [3:0] Fifo_Status;
    logic [7:0] Fifo_Data = 8'h00;
    logic       Read;
    logic       Tx;
    logic       Busy;
    logic       Tx_Done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int read_cnt = 0;
    int bad_pop = 0;
    int dbl_read = 0;
    logic prev_read = 1'b0;

    uart_tx_serializer #(.DATA_WIDTH(8), .BAUD_DIV(BAUD)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Tx_En       (Tx_En),
        .Fifo_Status (Fifo_Status),
        .Fifo_Data   (Fifo_Data),
        .Read        (Read),
        .Tx          (Tx),
        .Busy        (Busy),
        .Tx_Done     (Tx_Done)
    );

    always #5 Clk = ~Clk;

    assign Fifo_Status = {3'b000, (wr_ptr == rd_ptr)};

    // FIFO model with registered read data.
    always @(posedge Clk) begin
        prev_read <= Read;
        if (Read === 1'b1) begin
            read_cnt <= read_cnt + 1;
            if (prev_read === 1'b1) dbl_read <= dbl_read + 1;
            if (rd_ptr == wr_ptr) begin
                bad_pop <= bad_pop + 1;
            end else begin
                Fifo_Data <= mem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Waits (from a negedge) for the start bit, then checks every line cycle of the frame
    // and the Tx_Done pulse that must follow the last stop-bit cycle.
    task automatic check_frame(input logic [7:0] b, input string nm, input int drop_bit);
        logic expb [NB];
        logic got;
        bit   ok;
        int   bad;
        expb[0] = 1'b0;
        for (int i = 0; i < 8; i++) expb[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        expb[9] = ^b;
`endif
        expb[NB-1] = 1'b1;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            if (Tx === 1'b0) begin
                ok = 1;
                break;
            end
            @(negedge Clk);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s start_timeout: Tx=%b required 0 within 200 cycles", nm, Tx);
            return;
        end
        for (int k = 0; k < NB; k++) begin
            bad = 0;
            got = Tx;
            for (int c = 0; c < BAUD; c++) begin
                if (!(k == 0 && c == 0)) @(negedge Clk);
                if (k == drop_bit && c == 0) Tx_En = 1'b0;
                if (Tx !== expb[k] || Busy !== 1'b1 || Tx_Done !== 1'b0) begin
                    bad++;
                    got = Tx;
                end
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL %s bit%0d: Tx=%b Busy=%b Tx_Done=%b required Tx=%b Busy=1 Tx_Done=0 (%0d bad cycles)",
                         nm, k, got, Busy, Tx_Done, expb[k], bad);
            end
        end
        @(negedge Clk);
        n_cmp++;
        if (Tx_Done !== 1'b1 || Busy !== 1'b0 || Tx !== 1'b1) begin
            n_err++;
            $display("FAIL %s done: Tx_Done=%b Busy=%b Tx=%b required 1 0 1", nm, Tx_Done, Busy, Tx);
        end
    endtask

    task automatic test_reset();
        bit seen;
        Reset = 1'b0;
        Tx_En = 1'b1;
        push(8'h3C);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            n_cmp++;
            if (Tx !== 1'b1 || Read !== 1'b0 || Busy !== 1'b0 || Tx_Done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: Tx=%b Read=%b Busy=%b Tx_Done=%b required 1 0 0 0",
                         i, Tx, Read, Busy, Tx_Done);
            end
        end
        Reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            if (Read === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL reset_first_read: Read=%b required 1 within 2 cycles of release", Read);
        end
        check_frame(8'h3C, "reset_frame", -1);
    endtask

    task automatic test_single();
        int r0;
        bit seen;
        r0 = read_cnt;
        @(negedge Clk);
        push(8'hA5);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Read === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (!seen || Tx !== 1'b1 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_fetch: Read=%b Tx=%b Busy=%b required 1 1 1", Read, Tx, Busy);
        end
        @(negedge Clk);
        n_cmp++;
        if (Read !== 1'b0 || Tx !== 1'b1 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_load: Read=%b Tx=%b Busy=%b required 0 1 1", Read, Tx, Busy);
        end
        @(negedge Clk);
        n_cmp++;
        if (Tx !== 1'b0) begin
            n_err++;
            $display("FAIL single_start_latency: Tx=%b required 0", Tx);
        end
        check_frame(8'hA5, "single_A5", -1);
        repeat (5) @(negedge Clk);
        n_cmp++;
        if (read_cnt - r0 != 1) begin
            n_err++;
            $display("FAIL single_reads: reads=%0d required 1", read_cnt - r0);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        @(negedge Clk);
        push(8'h07);
        push(8'hA5);
        check_frame(8'h07, "parity_07", -1);
        check_frame(8'hA5, "parity_A5", -1);
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] w [3];
        int r0;
        int g;
        w[0] = 8'h11;
        w[1] = 8'h22;
        w[2] = 8'h33;
        r0 = read_cnt;
        @(negedge Clk);
        push(w[0]);
        push(w[1]);
        push(w[2]);
        for (int f = 0; f < 3; f++) begin
            check_frame(w[f], "b2b", -1);
            if (f < 2) begin
                g = 0;
                while (Tx === 1'b1 && g < 10) begin
                    g++;
                    @(negedge Clk);
                end
                n_cmp++;
                if (g != 3) begin
                    n_err++;
                    $display("FAIL b2b_gap%0d: idle=%0d required 3", f, g);
                end
            end
        end
        repeat (20) @(negedge Clk);
        n_cmp++;
        if (read_cnt - r0 != 3) begin
            n_err++;
            $display("FAIL b2b_reads: reads=%0d required 3", read_cnt - r0);
        end
    endtask

    task automatic test_tx_en_drop();
        int r0;
        int bad;
        r0 = read_cnt;
        @(negedge Clk);
        push(8'h5A);
        push(8'hC3);
        check_frame(8'h5A, "en_drop_f1", 3);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (Tx !== 1'b1 || Read !== 1'b0 || Busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || read_cnt - r0 != 1) begin
            n_err++;
            $display("FAIL en_drop_hold: reads=%0d bad_cycles=%0d required 1 0", read_cnt - r0, bad);
        end
        Tx_En = 1'b1;
        check_frame(8'hC3, "en_drop_f2", -1);
        n_cmp++;
        if (read_cnt - r0 != 2) begin
            n_err++;
            $display("FAIL en_drop_reads: reads=%0d required 2", read_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r0;
        r0 = read_cnt;
        @(negedge Clk);
        push(8'h4B);
        push(8'h96);
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge Clk);
            if (Tx === 1'b0) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL rmid_start: Tx=%b required 0", Tx);
            return;
        end
        repeat (3 * BAUD) @(negedge Clk);
        n_cmp++;
        if (Tx !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_bit2: Tx=%b required 0", Tx);
        end
        Reset = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (Tx !== 1'b1 || Busy !== 1'b0 || Tx_Done !== 1'b0 || Read !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_abort: Tx=%b Busy=%b Tx_Done=%b Read=%b required 1 0 0 0",
                     Tx, Busy, Tx_Done, Read);
        end
        Reset = 1'b1;
        check_frame(8'h96, "rmid_next", -1);
        n_cmp++;
        if (read_cnt - r0 != 2) begin
            n_err++;
            $display("FAIL rmid_reads: reads=%0d required 2", read_cnt - r0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_tx_en_drop();
        test_reset_mid();
        repeat (5) @(negedge Clk);
        n_cmp++;
        if (bad_pop != 0 || dbl_read != 0) begin
            n_err++;
            $display("FAIL read_hygiene: empty_pops=%0d double_reads=%0d required 0 0", bad_pop, dbl_read);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
